// File: rtl/icache.sv
// Direct-mapped, 16-frame, one-word-per-block instruction cache between fetch and the memory arbiter.
// Hits return combinationally. A miss fetches one word, fills the frame, and hits from the array on the next cycle.
package cpu_types_pkg;
  localparam int IIDX_W = 4;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  bytoff;
  } icachef_t;

  typedef struct packed {
    logic        valid;
    logic [25:0] tag;
    logic [31:0] data;
  } icache_frame;
endpackage

// state | meaning
// IDLE  | serve hits from the array; a miss latches the word address
// FETCH | iREN held with the latched address until iwait drops (fill) or flush (abort)
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  import cpu_types_pkg::*;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      r_state;
  state_t      w_next;
  icache_frame r_frames [SETS];
  word_t       r_miss_addr;

  icachef_t    w_req;
  icachef_t    w_miss;
  icache_frame w_frame;
  logic        w_match;
  logic        w_fill;
  logic        w_latch;
  logic        w_unused_bits;

  assign w_req         = icachef_t'(imemaddr);
  assign w_miss        = icachef_t'(r_miss_addr);
  assign w_frame       = r_frames[w_req.idx];
  assign w_match       = imemREN & w_frame.valid & (w_frame.tag == w_req.tag);
  assign w_unused_bits = ^{w_req.bytoff, w_miss.bytoff};

  // Data is presented regardless of hit; the fetch stage qualifies it with ihit.
  assign imemload = w_frame.data;
  assign iaddr    = r_miss_addr;

  always_comb begin
    w_next  = r_state;
    ihit    = 1'b0;
    iREN    = 1'b0;
    w_fill  = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      IDLE: begin
        ihit = w_match & ~flush;
        if (!flush && imemREN && !w_match) begin
          w_latch = 1'b1;
          w_next  = FETCH;
        end
      end
      FETCH: begin
        iREN = 1'b1;
        // Flush wins over a completing fill in the same cycle.
        if (flush) begin
          w_next = IDLE;
        end else if (!iwait) begin
          w_fill = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      for (int i = 0; i < SETS; i++) begin
        r_frames[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_miss_addr <= {imemaddr[31:2], 2'b00};
      end
      if (flush) begin
        for (int i = 0; i < SETS; i++) begin
          r_frames[i].valid <= 1'b0;
        end
      end else if (w_fill) begin
        r_frames[w_miss.idx] <= '{valid: 1'b1, tag: w_miss.tag, data: iload};
      end
    end
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, 16-entry, one-word-per-block instruction cache between the fetch stage and the memory arbiter. The fetch stage presents a PC and expects the instruction back, with `ihit` qualifying it. On a miss the block latches the address and requests the word from memory. It then fills the frame and returns the instruction from the array on the cycle after the fill. The frame layout is `icache_frame` and the address split is `icachef_t` from `cpu_types_pkg`.

## Interface
- `SETS`, 16: number of frames; must equal 2**IIDX_W.
- `CLK`  in  1  system clock, rising-edge.
- `nRST`  in  1  asynchronous active-low reset.
- `imemREN`  in  1  fetch stage requests an instruction.
- `imemaddr`  in  32  fetch PC (word_t), interpreted as icachef_t.
- `flush`  in  1  synchronous invalidate-all.
- `ihit`  out  1  `imemload` is valid for `imemaddr` this cycle.
- `imemload`  out  32  instruction to fetch stage.
- `iREN`  out  1  read request to memory arbiter.
- `iaddr`  out  32  word-aligned memory read address.
- `iwait`  in  1  memory busy; low means `iload` is valid this cycle.
- `iload`  in  32  memory read data.

## Operation
- Address split:
  - tag = `imemaddr[31:6]` (26 bits).
  - idx = `imemaddr[5:2]` (4 bits).
  - bytoff = `imemaddr[1:0]`, ignored.
- Storage: SETS × icache_frame {valid, tag[25:0], data[31:0]}. Only `flush` and fills write it.
- FSM states are IDLE and FETCH.
- IDLE:
  - Hit = `imemREN` & frame[idx].valid & (frame[idx].tag == tag).
  - Hit behaviour: combinational; `ihit`=1 and `imemload`=frame[idx].data in the same cycle.
  - Miss with `imemREN`=1: latch `{imemaddr[31:2],2'b00}` into miss_addr and go to FETCH.
  - `imemREN`=0: `ihit`=0; stay in IDLE.
- FETCH:
  - `iREN`=1, `iaddr`=miss_addr, `ihit`=0.
  - On `iwait`=0: write frame[miss_addr.idx] = {1, miss_addr.tag, iload}, then return to IDLE.
  - Leaving the state does not raise `ihit`.
- Fetch-stage changes mid-miss: `imemaddr` or `imemREN` changing during FETCH has no effect. The latched request completes and fills; the next access is then re-evaluated in IDLE.
- `flush`: clears every valid bit at the clock edge; data and tag bits are don't-care.
  - Flush in IDLE: stay in IDLE; `ihit` is 0 in that cycle.
  - Flush in FETCH: abort and return to IDLE with no fill, even if `iwait`=0 in that cycle.
- `imemload` with `ihit`=0: frame[idx].data (don't-care); checkers must only sample when `ihit`=1.
- `iaddr` in IDLE: miss_addr (don't-care while `iREN`=0).

## Timing
- Reset (async, `nRST`=0):
  - State = IDLE; all valid = 0; miss_addr = 0.
  - `ihit`=0, `iREN`=0, `iaddr`=0, `imemload`=0 (array zeroed).
  - Reset mid-FETCH deasserts `iREN` immediately and asynchronously.
- Hit latency is 0 cycles (combinational).
- Miss latency is N+2 cycles from miss detection to `ihit`, where N is the number of `iwait`=1 cycles:
  - Cycle 0: miss is detected.
  - Cycles 1..N+1: FETCH.
  - Cycle N+2: hit from the array.
- `iREN` rises the cycle after miss detection. It stays high through the cycle in which `iwait`=0 and is low the next cycle.
- `iaddr` is stable for the whole time `iREN` is high.
- Back-to-back misses insert one IDLE cycle between requests, so `iREN` is low for exactly one cycle.
- Same-index conflicts: a fill overwrites the previous frame at that index with no writeback (read-only cache).
- `flush` and `iwait`=0 in the same FETCH cycle: `flush` wins.

## Test plan
- Reset, then `imemREN`=1, `imemaddr`=0x0000_0000, memory returns 0x2001_0005 after 3 wait cycles:
  - `iREN`=1 with `iaddr`=0x0 for 4 cycles.
  - `ihit`=1 and `imemload`=0x2001_0005 on cycle 5.
  - The re-access is a 0-latency hit.
- Fill 0x0000_0004 (data 0xAAAA_AAAA), then access 0x0000_0044 (same idx 1, different tag):
  - Miss; fill 0xBBBB_BBBB.
  - A re-access to 0x4 misses again.
- Miss on 0x0000_0010; during FETCH drive `imemaddr`=0x0000_0100 and `imemREN`=0:
  - `iaddr` stays 0x10 and frame 4 fills.
  - Back in IDLE, 0x100 is evaluated as a miss.
- Fill all 16 indices, assert `flush` for one cycle:
  - All subsequent accesses miss.
  - `flush` asserted mid-FETCH with `iwait`=0 in the same cycle: no fill; that address still misses.
- Assert `nRST`=0 while FETCH is waiting:
  - `iREN` drops without a clock edge.
  - After release, a previously filled address misses.
- Sequential PC stream 0x0, 0x4, ... 0x3C with 1-cycle memory:
  - Each word takes 3 cycles cold.
  - The second pass hits every cycle with correct data.
